// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: reads opcode and operand bytes one at a time,
// advances the PC through the register file and hands the instruction to decode.
module cpu_fetch_unit #(
    parameter int         MEM_LATENCY                = 1,
    parameter logic [7:0] RESET_VECTOR_UNUSED_OPCODE = 8'hEA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic [15:0] pc_in,
    output logic        we_pc,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        fetch_req,
    input  logic        flush,
    output logic        busy,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  opcode,
    output logic [15:0] operand,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_OP = 3'd1;
    localparam logic [2:0] S_WAIT_LO = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [3:0] lo;
        logic [3:0] hi;
        logic [1:0] len;
        lo = op[3:0];
        hi = op[7:4];
        if (lo == 4'h8 || lo == 4'hA ||
            op == 8'h00 || op == 8'h40 || op == 8'h60)
            len = 2'd1;
        else if (lo >= 4'hC || op == 8'h20 ||
                 ((lo == 4'h9 || lo == 4'hB) && hi[0]))
            len = 2'd3;
        else
            len = 2'd2;
        return len;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] pc_in_q, pc_in_d;
    logic        we_pc_q, we_pc_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        busy_q;
    logic        valid_q, valid_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [1:0]  len_q, len_d;
    logic [15:0] ipc_q, ipc_d;
    logic        issue;
    logic [1:0]  rd_len;

    assign rd_len = decode_len(mem_rdata);

    // Next-state: wait for each byte, capture it, then issue the next one
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_in_d    = pc_in_q;
        we_pc_d    = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        valid_d    = valid_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        len_d      = len_q;
        ipc_d      = ipc_q;
        issue      = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_req) begin
                        ipc_d   = pc;
                        issue   = 1'b1;
                        state_d = S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        opcode_d  = mem_rdata;
                        operand_d = 16'h0000;
                        len_d     = rd_len;
                        if (rd_len == 2'd1) begin
                            valid_d = 1'b1;
                            state_d = S_HOLD;
                        end else begin
                            issue   = 1'b1;
                            state_d = S_WAIT_LO;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        operand_d[7:0] = mem_rdata;
                        if (len_q == 2'd2) begin
                            valid_d = 1'b1;
                            state_d = S_HOLD;
                        end else begin
                            issue   = 1'b1;
                            state_d = S_WAIT_HI;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        operand_d[15:8] = mem_rdata;
                        valid_d         = 1'b1;
                        state_d         = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (issue) begin
            mem_addr_d = pc;
            mem_rd_d   = 1'b1;
            pc_in_d    = pc + 16'd1;
            we_pc_d    = 1'b1;
            cnt_d      = LAT;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            pc_in_q    <= 16'h0000;
            we_pc_q    <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            opcode_q   <= RESET_VECTOR_UNUSED_OPCODE;
            operand_q  <= 16'h0000;
            len_q      <= 2'd1;
            ipc_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_in_q    <= pc_in_d;
            we_pc_q    <= we_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            busy_q     <= (state_d != S_IDLE);
            valid_q    <= valid_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
            len_q      <= len_d;
            ipc_q      <= ipc_d;
        end
    end

    assign pc_in       = pc_in_q;
    assign we_pc       = we_pc_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign busy        = busy_q;
    assign instr_valid = valid_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_len   = len_q;
    assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: two instances (latency 1 and 3) checked each
// cycle against a schedule-based instruction model, plus directed literals.
`timescale 1ns/1ps
module tb_cpu_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [65536];

    logic [1:0]       reset_v, fetch_v, flush_v, ready_v, pcld_v;
    logic [1:0][15:0] pcval_v;

    logic [1:0]       busy_v, valid_v, rd_v, we_v;
    logic [1:0][15:0] pc_v, operand_v, ipc_v, addr_v, pcin_v;
    logic [1:0][7:0]  op_v;
    logic [1:0][1:0]  len_v;

    task automatic chk(input string nm, input int ln,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d got=%0h want=%0h t=%0t",
                     nm, ln, act, exp, $time);
        end
    endtask

    function automatic int ref_len(input logic [7:0] op);
        int o, lo, hi;
        o  = int'(op);
        lo = o % 16;
        hi = o / 16;
        if (lo == 8 || lo == 10 || o == 0 || o == 64 || o == 96) return 1;
        if (lo >= 12 || o == 32 || ((lo == 9 || lo == 11) && hi % 2 == 1))
            return 3;
        return 2;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int L = (k == 0) ? 1 : 3;
        localparam int P = L + 1;

        logic [15:0] pcr, pc_in, mem_addr, operand, instr_pc;
        logic        we_pc, mem_rd, busy, instr_valid;
        logic [7:0]  rdata, opcode;
        logic [1:0]  instr_len;
        logic [16:0] stg [8];

        cpu_fetch_unit #(.MEM_LATENCY(L)) dut (
            .clk(clk), .reset(reset_v[k]), .pc(pcr), .pc_in(pc_in),
            .we_pc(we_pc), .mem_addr(mem_addr), .mem_rd(mem_rd),
            .mem_rdata(rdata), .fetch_req(fetch_v[k]), .flush(flush_v[k]),
            .busy(busy), .instr_valid(instr_valid),
            .instr_ready(ready_v[k]), .opcode(opcode), .operand(operand),
            .instr_len(instr_len), .instr_pc(instr_pc)
        );

        always @(posedge clk) begin
            stg[0] <= {mem_rd, mem_addr};
            for (int i = 1; i < 8; i++) stg[i] <= stg[i-1];
        end
        assign rdata = stg[L-1][16] ? mem[stg[L-1][15:0]] : 8'hFF;

        always @(posedge clk) begin
            if (we_pc) pcr <= pc_in;
            else if (pcld_v[k]) pcr <= pcval_v[k];
        end

        assign busy_v[k]    = busy;
        assign valid_v[k]   = instr_valid;
        assign rd_v[k]      = mem_rd;
        assign we_v[k]      = we_pc;
        assign pc_v[k]      = pcr;
        assign operand_v[k] = operand;
        assign ipc_v[k]     = instr_pc;
        assign addr_v[k]    = mem_addr;
        assign pcin_v[k]    = pc_in;
        assign op_v[k]      = opcode;
        assign len_v[k]     = instr_len;

        bit          armed, m_act, m_hold, e_rd, e_we;
        int          t, n;
        logic [15:0] mpc, pc0, e_addr, e_pcin, e_opnd, e_ipc;
        logic [7:0]  e_op;
        logic [1:0]  e_len;

        initial begin : mdl
            logic        o_we;
            logic [15:0] o_pcin, o_mpc;
            logic [7:0]  b1, b2;
            forever begin
                @(posedge clk);
                o_we   = e_we;
                o_pcin = e_pcin;
                o_mpc  = mpc;
                e_rd   = 1'b0;
                e_we   = 1'b0;
                if (reset_v[k]) begin
                    armed  = 1'b1;
                    m_act  = 1'b0;
                    m_hold = 1'b0;
                    e_addr = 16'h0;
                    e_pcin = 16'h0;
                end else if (flush_v[k]) begin
                    m_act  = 1'b0;
                    m_hold = 1'b0;
                end else if (m_hold) begin
                    if (ready_v[k]) m_hold = 1'b0;
                end else if (!m_act && fetch_v[k]) begin
                    m_act = 1'b1;
                    t     = 0;
                    pc0   = o_mpc;
                    e_ipc = o_mpc;
                    e_op  = mem[o_mpc];
                    b1    = mem[16'(o_mpc + 16'd1)];
                    b2    = mem[16'(o_mpc + 16'd2)];
                    n     = ref_len(e_op);
                    e_len = 2'(n);
                    if (n == 1) e_opnd = 16'h0;
                    else if (n == 2) e_opnd = {8'h00, b1};
                    else e_opnd = {b2, b1};
                end
                if (m_act) begin
                    t++;
                    if ((t - 1) % P == 0 && (t - 1) / P < n) begin
                        e_rd   = 1'b1;
                        e_we   = 1'b1;
                        e_addr = pc0 + 16'((t - 1) / P);
                        e_pcin = e_addr + 16'd1;
                    end
                    if (t == n * P + 1) begin
                        m_act  = 1'b0;
                        m_hold = 1'b1;
                    end
                end
                if (o_we) mpc = o_pcin;
                else if (pcld_v[k]) mpc = pcval_v[k];
            end
        end

        initial forever begin
            @(negedge clk);
            if (armed) begin
                chk("instr_valid", k, instr_valid, m_hold);
                chk("busy", k, busy, m_act || m_hold);
                chk("mem_rd", k, mem_rd, e_rd);
                chk("we_pc", k, we_pc, e_we);
                if (e_rd) chk("mem_addr", k, mem_addr, e_addr);
                if (e_we) chk("pc_in", k, pc_in, e_pcin);
                if (m_hold) begin
                    chk("opcode", k, opcode, e_op);
                    chk("operand", k, operand, e_opnd);
                    chk("instr_len", k, instr_len, e_len);
                    chk("instr_pc", k, instr_pc, e_ipc);
                end
            end
        end
    end

    task automatic load_pc(input int ln, input logic [15:0] v);
        pcld_v[ln]  = 1'b1;
        pcval_v[ln] = v;
        @(negedge clk);
        pcld_v[ln] = 1'b0;
    endtask

    task automatic fetch(input int ln, input int exp_lat, input int exp_we);
        int k, wec;
        fetch_v[ln] = 1'b1;
        @(negedge clk);
        fetch_v[ln] = 1'b0;
        k   = 1;
        wec = 0;
        while (!valid_v[ln] && k < 80) begin
            wec += int'(we_v[ln]);
            @(negedge clk);
            k++;
        end
        chk("latency", ln, k, exp_lat);
        chk("we_pulses", ln, wec, exp_we);
    endtask

    task automatic fields(input int ln, input logic [7:0] op,
                          input logic [15:0] opnd, input logic [1:0] len,
                          input logic [15:0] ipc);
        chk("lit_opcode", ln, op_v[ln], op);
        chk("lit_operand", ln, operand_v[ln], opnd);
        chk("lit_len", ln, len_v[ln], len);
        chk("lit_instr_pc", ln, ipc_v[ln], ipc);
    endtask

    task automatic accept(input int ln);
        ready_v[ln] = 1'b1;
        @(negedge clk);
        ready_v[ln] = 1'b0;
        chk("idle_after_accept", ln, busy_v[ln], 0);
    endtask

    task automatic reset_vals(input int ln);
        fields(ln, 8'hEA, 16'h0, 2'd1, 16'h0);
        chk("rst_mem_addr", ln, addr_v[ln], 0);
        chk("rst_pc_in", ln, pcin_v[ln], 0);
        chk("rst_mem_rd", ln, rd_v[ln], 0);
        chk("rst_we_pc", ln, we_v[ln], 0);
        chk("rst_valid", ln, valid_v[ln], 0);
        chk("rst_busy", ln, busy_v[ln], 0);
    endtask

    task automatic rand_phase(input int ln);
        logic [15:0] v;
        int c;
        for (int r = 0; r < 25; r++) begin
            v = ($urandom_range(0, 3) == 0) ?
                16'(16'hFFFF - 16'($urandom_range(0, 4))) : 16'($urandom);
            load_pc(ln, v);
            for (int i = 0; i < 30; i++) begin
                fetch_v[ln] = ($urandom_range(0, 2) == 0);
                ready_v[ln] = ($urandom_range(0, 1) == 0);
                flush_v[ln] = ($urandom_range(0, 39) == 0);
                @(negedge clk);
            end
            fetch_v[ln] = 1'b0;
            flush_v[ln] = 1'b0;
            ready_v[ln] = 1'b1;
            c = 0;
            while (busy_v[ln] && c < 60) begin
                @(negedge clk);
                c++;
            end
            chk("drain", ln, busy_v[ln], 0);
            ready_v[ln] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sawv;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        reset_v = 2'b11;
        fetch_v = 2'b00;
        flush_v = 2'b00;
        ready_v = 2'b00;
        pcld_v  = 2'b11;
        pcval_v = '0;
        repeat (2) @(negedge clk);
        reset_v = 2'b00;
        pcld_v  = 2'b00;
        reset_vals(0);
        reset_vals(1);

        mem[16'h1000] = 8'hEA;
        load_pc(0, 16'h1000);
        fetch(0, 3, 1);
        fields(0, 8'hEA, 16'h0000, 2'd1, 16'h1000);
        chk("pc_after", 0, pc_v[0], 16'h1001);
        accept(0);

        mem[16'h1000] = 8'hAD;
        mem[16'h1001] = 8'h34;
        mem[16'h1002] = 8'h12;
        load_pc(0, 16'h1000);
        fetch(0, 7, 3);
        fields(0, 8'hAD, 16'h1234, 2'd3, 16'h1000);
        chk("pc_after", 0, pc_v[0], 16'h1003);
        accept(0);

        mem[16'hFFFF] = 8'hA9;
        mem[16'h0000] = 8'h05;
        load_pc(0, 16'hFFFF);
        fetch(0, 5, 2);
        fields(0, 8'hA9, 16'h0005, 2'd2, 16'hFFFF);
        chk("pc_wrap", 0, pc_v[0], 16'h0001);
        accept(0);

        mem[16'h2000] = 8'h18;
        load_pc(0, 16'h2000);
        fetch(0, 3, 1);
        for (int i = 0; i < 5; i++) begin
            fetch_v[0] = 1'b1;
            @(negedge clk);
            chk("hold_busy", 0, busy_v[0], 1);
            chk("hold_valid", 0, valid_v[0], 1);
        end
        fields(0, 8'h18, 16'h0000, 2'd1, 16'h2000);
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        fetch_v[0] = 1'b0;
        chk("accept_valid", 0, valid_v[0], 0);
        chk("accept_busy", 0, busy_v[0], 0);
        @(negedge clk);
        chk("no_queued_fetch", 0, busy_v[0], 0);
        chk("pc_hold", 0, pc_v[0], 16'h2001);

        load_pc(0, 16'h1000);
        fetch_v[0] = 1'b1;
        @(negedge clk);
        fetch_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lo_issue", 0, rd_v[0], 1);
        flush_v[0] = 1'b1;
        @(negedge clk);
        flush_v[0] = 1'b0;
        chk("flush_busy", 0, busy_v[0], 0);
        chk("flush_mem_rd", 0, rd_v[0], 0);
        sawv = 0;
        for (int i = 0; i < 10; i++) begin
            sawv += int'(valid_v[0]);
            @(negedge clk);
        end
        chk("flush_no_valid", 0, sawv, 0);
        chk("flush_pc", 0, pc_v[0], 16'h1002);

        load_pc(0, 16'h1000);
        fetch_v[0] = 1'b1;
        @(negedge clk);
        fetch_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("hi_issue", 0, rd_v[0], 1);
        reset_v[0] = 1'b1;
        @(negedge clk);
        reset_v[0] = 1'b0;
        reset_vals(0);
        chk("reset_pc", 0, pc_v[0], 16'h1003);

        mem[16'h3000] = 8'h20;
        mem[16'h3001] = 8'h00;
        mem[16'h3002] = 8'h20;
        load_pc(1, 16'h3000);
        fetch(1, 13, 3);
        fields(1, 8'h20, 16'h2000, 2'd3, 16'h3000);
        chk("pc_after", 1, pc_v[1], 16'h3003);
        accept(1);

        mem[16'h3100] = 8'hEA;
        load_pc(1, 16'h3100);
        fetch(1, 5, 1);
        fields(1, 8'hEA, 16'h0000, 2'd1, 16'h3100);
        accept(1);

        rand_phase(0);
        rand_phase(1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
